// File: rtl/snd_fade.sv
// Click-free fade-in/fade-out envelope for a 1-bit sound stream.
// Intermediate levels are rendered by a first-order sigma-delta so the output stays 1 bit.
module snd_fade #(
  parameter int LEVEL_BITS = 8,
  parameter int RAMP_DIV   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  snd_in,
  input  logic                  enable,
  output logic                  snd_out,
  output logic [LEVEL_BITS-1:0] level,
  output logic [1:0]            state
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0]         PS_LAST  = PW'(RAMP_DIV - 1);
  localparam logic [LEVEL_BITS-1:0] LVL_MAX  = '1;
  localparam logic [LEVEL_BITS-1:0] LVL_NEAR = LVL_MAX - LEVEL_BITS'(1);
  localparam logic [LEVEL_BITS-1:0] LVL_ONE  = LEVEL_BITS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LEVEL_BITS-1:0] level_q, level_d;
  logic [LEVEL_BITS-1:0] acc_q, acc_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  snd_out_q, snd_out_d;

  logic [LEVEL_BITS-1:0] sd_x;
  logic [LEVEL_BITS:0]   sd_sum;
  logic                  step;

  assign sd_x   = snd_in ? level_q : '0;
  assign sd_sum = {1'b0, acc_q} + {1'b0, sd_x};
  assign step   = (presc_q == PS_LAST);

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    acc_d     = acc_q;
    presc_d   = presc_q;
    snd_out_d = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = '0;
        acc_d   = '0;
        if (enable) begin
          state_d = RAMP_UP;
          presc_d = '0;
        end
      end
      ON: begin
        level_d   = LVL_MAX;
        acc_d     = '0;
        snd_out_d = snd_in;
        if (!enable) begin
          state_d = RAMP_DOWN;
          presc_d = '0;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        snd_out_d = sd_sum[LEVEL_BITS];
        acc_d     = sd_sum[LEVEL_BITS-1:0];
        // A direction change wins over a coincident step and keeps the level.
        if ((state_q == RAMP_UP) != enable) begin
          state_d = enable ? RAMP_UP : RAMP_DOWN;
          presc_d = '0;
        end else if (step) begin
          presc_d = '0;
          if (state_q == RAMP_UP) begin
            if (level_q >= LVL_NEAR) begin
              level_d = LVL_MAX;
              state_d = ON;
            end else begin
              level_d = level_q + LVL_ONE;
            end
          end else begin
            if (level_q <= LVL_ONE) begin
              level_d = '0;
              state_d = IDLE;
            end else begin
              level_d = level_q - LVL_ONE;
            end
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      level_q   <= '0;
      acc_q     <= '0;
      presc_q   <= '0;
      snd_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      acc_q     <= acc_d;
      presc_q   <= presc_d;
      snd_out_q <= snd_out_d;
    end
  end

  assign snd_out = snd_out_q;
  assign level   = level_q;
  assign state   = state_q;

endmodule

// File: tb/tb_snd_fade.sv
// Scoreboard bench for snd_fade: directed envelope timing, random enable/sound traffic
// against a reference model, and sigma-delta density on a slow-ramp instance.
module tb_snd_fade;

  localparam int LB   = 4;
  localparam int RD   = 4;
  localparam int MAXL = (1 << LB) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, snd_in, enable, snd_out;
  logic [LB-1:0] level;
  logic [1:0]    state;

  logic          rst2_n, snd_in2, enable2, snd_out2;
  logic [LB-1:0] level2;
  logic [1:0]    state2;

  snd_fade #(.LEVEL_BITS(LB), .RAMP_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .snd_in(snd_in), .enable(enable),
    .snd_out(snd_out), .level(level), .state(state)
  );

  snd_fade #(.LEVEL_BITS(LB), .RAMP_DIV(256)) dut2 (
    .clk(clk), .rst_n(rst2_n), .snd_in(snd_in2), .enable(enable2),
    .snd_out(snd_out2), .level(level2), .state(state2)
  );

  int passed = 0;
  int total  = 0;
  bit done2  = 1'b0;

  typedef struct {
    int o;
    int lvl;
    int st;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: state 0 idle, 1 rising, 2 full, 3 falling
  int m_state = 0, m_level = 0, m_cnt = 0, m_acc = 0;

  function automatic void chk(string name, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic model_step(input logic r, input logic en, input logic din);
    int   ns, nl, nc, na, no, total_in;
    ns = m_state; nl = m_level; nc = m_cnt; na = m_acc; no = 0;
    if (!r) begin
      ns = 0; nl = 0; nc = 0; na = 0; no = 0;
    end else begin
      case (m_state)
        0: begin
          nl = 0; na = 0;
          if (en) begin ns = 1; nc = 0; end
        end
        2: begin
          na = 0; no = din ? 1 : 0;
          if (!en) begin ns = 3; nc = 0; end
        end
        default: begin
          total_in = m_acc + (din ? m_level : 0);
          no = (total_in >= (1 << LB)) ? 1 : 0;
          na = total_in % (1 << LB);
          if (m_state == 1 && !en) begin ns = 3; nc = 0; end
          else if (m_state == 3 && en) begin ns = 1; nc = 0; end
          else if (m_cnt == RD - 1) begin
            nc = 0;
            if (m_state == 1) begin
              nl = (m_level + 1 > MAXL) ? MAXL : m_level + 1;
              if (nl == MAXL) ns = 2;
            end else begin
              nl = (m_level - 1 < 0) ? 0 : m_level - 1;
              if (nl == 0) ns = 0;
            end
          end else begin
            nc = m_cnt + 1;
          end
        end
      endcase
    end
    m_state = ns; m_level = nl; m_cnt = nc; m_acc = na;
    sb_q.push_back('{o: no, lvl: nl, st: ns});
  endtask

  // Drive inputs on the falling edge, predict the next rising edge, return just after it.
  task automatic cycle(input logic r, input logic en, input logic din);
    @(negedge clk);
    rst_n  = r;
    enable = en;
    snd_in = din;
    model_step(r, en, din);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sb_snd_out", int'(snd_out), e.o);
        chk("sb_level", int'(level), e.lvl);
        chk("sb_state", int'(state), e.st);
      end
    end
  end

  initial begin : main
    logic d;
    int   hold;
    logic ren;
    rst_n = 1'b0; enable = 1'b1; snd_in = 1'b0;

    // Reset held with enable high and toggling sound
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'(i % 2));
      chk("rst_snd_out", int'(snd_out), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_state", int'(state), 0);
    end
    cycle(1'b1, 1'b1, rbit());
    chk("rel_state", int'(state), 1);
    $display("reset phase done");

    // Drop back to idle, then full fade-in from edge k
    for (int j = 0; j < 6; j++) cycle(1'b1, 1'b0, rbit());
    chk("idle_state", int'(state), 0);
    cycle(1'b1, 1'b1, rbit());
    chk("fin_k_state", int'(state), 1);
    for (int j = 1; j <= 60; j++) begin
      cycle(1'b1, 1'b1, rbit());
      if (j == 3)  chk("fin_k3_level", int'(level), 0);
      if (j == 4)  chk("fin_k4_level", int'(level), 1);
      if (j == 32) chk("fin_k32_level", int'(level), 8);
      if (j == 59) chk("fin_k59_state", int'(state), 1);
      if (j == 60) begin
        chk("fin_k60_state", int'(state), 2);
        chk("fin_k60_level", int'(level), MAXL);
      end
    end
    for (int j = 0; j < 20; j++) begin
      d = rbit();
      cycle(1'b1, 1'b1, d);
      chk("passthru", int'(snd_out), int'(d));
    end
    $display("fade-in phase done");

    // Full fade-out from edge m
    cycle(1'b1, 1'b0, rbit());
    chk("fout_m_state", int'(state), 3);
    chk("fout_m_level", int'(level), MAXL);
    for (int j = 1; j <= 60; j++) begin
      cycle(1'b1, 1'b0, rbit());
      if (j == 4)  chk("fout_m4_level", int'(level), 14);
      if (j == 59) chk("fout_m59_level", int'(level), 1);
      if (j == 60) begin
        chk("fout_m60_state", int'(state), 0);
        chk("fout_m60_level", int'(level), 0);
      end
    end
    for (int j = 0; j < 10; j++) begin
      cycle(1'b1, 1'b0, 1'b1);
      chk("fout_silent", int'(snd_out), 0);
    end
    $display("fade-out phase done");

    // Reversal mid-ramp
    cycle(1'b1, 1'b1, rbit());
    for (int j = 1; j <= 24; j++) cycle(1'b1, 1'b1, rbit());
    chk("rev_up_level6", int'(level), 6);
    cycle(1'b1, 1'b0, rbit());
    chk("rev_down_state", int'(state), 3);
    for (int j = 1; j <= 8; j++) begin
      cycle(1'b1, 1'b0, rbit());
      if (j == 4) chk("rev_e4_level", int'(level), 5);
      if (j == 8) chk("rev_e8_level", int'(level), 4);
    end
    cycle(1'b1, 1'b1, rbit());
    chk("rev_r_state", int'(state), 1);
    chk("rev_r_level", int'(level), 4);
    for (int j = 1; j <= 44; j++) begin
      cycle(1'b1, 1'b1, rbit());
      if (j == 3)  chk("rev_r3_level", int'(level), 4);
      if (j == 4)  chk("rev_r4_level", int'(level), 5);
      if (j == 8)  chk("rev_r8_level", int'(level), 6);
      if (j == 43) chk("rev_r43_state", int'(state), 1);
      if (j == 44) chk("rev_r44_state", int'(state), 2);
    end
    for (int j = 0; j < 70; j++) cycle(1'b1, 1'b0, rbit());
    $display("reversal phase done");

    // Asynchronous reset mid-ramp at level 9
    cycle(1'b1, 1'b1, rbit());
    for (int j = 1; j <= 37; j++) cycle(1'b1, 1'b1, 1'b1);
    chk("ar_pre_level", int'(level), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_snd_out", int'(snd_out), 0);
    chk("ar_level", int'(level), 0);
    chk("ar_state", int'(state), 0);
    m_state = 0; m_level = 0; m_cnt = 0; m_acc = 0;
    for (int j = 0; j < 3; j++) cycle(1'b0, 1'b1, rbit());
    cycle(1'b1, 1'b1, rbit());
    chk("ar_rel_state", int'(state), 1);
    chk("ar_rel_level", int'(level), 0);
    for (int j = 1; j <= 4; j++) cycle(1'b1, 1'b1, rbit());
    chk("ar_restart_level", int'(level), 1);
    $display("async reset phase done");

    // Random enable bursts against the model
    hold = 0; ren = 1'b1;
    for (int j = 0; j < 1500; j++) begin
      if (hold == 0) begin
        ren  = rbit();
        hold = $urandom_range(1, 80);
      end
      hold--;
      cycle(1'b1, ren, rbit());
    end
    $display("random phase done");

    cycle(1'b1, 1'b0, 1'b0);
    chk("sb_drain", sb_q.size(), 0);

    for (int i = 0; i < 20000 && !done2; i++) @(posedge clk);
    if (!done2) chk("density_timeout", 0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Density of the sigma-delta on the slow instance (snd_in=1, constant level)
  initial begin : density
    int hist_o[$];
    int hist_l[$];
    int prev_l, prev_s, ones, l0, nwin;
    bit same;
    rst2_n = 1'b0; enable2 = 1'b0; snd_in2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1; enable2 = 1'b1;
    prev_l = 0; prev_s = 0; nwin = 0;
    for (int c = 0; c < 3400; c++) begin
      @(posedge clk);
      #1;
      hist_o.push_back(int'(snd_out2));
      hist_l.push_back((prev_s == 1) ? prev_l : -1);
      if (hist_o.size() > 16) begin
        void'(hist_o.pop_front());
        void'(hist_l.pop_front());
      end
      if (hist_o.size() == 16) begin
        l0 = hist_l[0];
        same = 1'b1;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
          if (hist_l[i] != l0) same = 1'b0;
          ones += hist_o[i];
        end
        if (same && (l0 == 4 || l0 == 12)) begin
          nwin++;
          chk("density_ones", ones, l0);
        end
      end
      prev_l = int'(level2);
      prev_s = int'(state2);
    end
    chk("density_windows", nwin, 2 * 241);
    $display("density windows checked: %0d", nwin);
    @(negedge clk);
    snd_in2 = 1'b0;
    for (int c = 0; c < 48; c++) begin
      @(posedge clk);
      #1;
      chk("density_zero_in", int'(snd_out2), 0);
    end
    done2 = 1'b1;
  end

endmodule

// File: doc/snd_fade.md
Name: snd_fade

Overview:
- Output conditioning stage directly downstream of the logistic_snd generator.
- Takes the generator's 1-bit square-wave sound and applies a click-free fade-in/fade-out envelope under an enable request.
- Scaling is done with a first-order sigma-delta modulator, so the output is still a single bit and drives the audio pin or PWM filter directly.
- Pass-through at full level; silence when idle.

Parameters:
- LEVEL_BITS, 8, envelope resolution; MAX = 2^LEVEL_BITS-1.
- RAMP_DIV, 1024, clocks per envelope step (>=1); full ramp = MAX*RAMP_DIV clocks.

Ports:
- clk  input  1  system clock (25 MHz nominal)
- rst_n  input  1  asynchronous active-low reset
- snd_in  input  1  raw sound bit from logistic_snd, synchronous to clk
- enable  input  1  sound request: 1 = fade in/stay on, 0 = fade out/stay off
- snd_out  output  1  registered, enveloped sound bit
- level  output  LEVEL_BITS  current envelope level
- state  output  2  FSM state: 0 IDLE, 1 RAMP_UP, 2 ON, 3 RAMP_DOWN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, level=0, prescaler=0, sigma-delta accumulator acc=0, snd_out=0.
  - Release is sampled on the next clk rising edge.
- All registers update on the clk rising edge. snd_out is registered: 1 cycle latency from snd_in.
- IDLE:
  - level=0, snd_out=0, acc held at 0.
  - enable=1 -> RAMP_UP, prescaler<=0.
- RAMP_UP:
  - prescaler increments every cycle.
  - When prescaler==RAMP_DIV-1: prescaler<=0 and level<=level+1.
  - If level+1==MAX, go to ON on the same edge.
  - enable=0 -> RAMP_DOWN on that edge, prescaler<=0, level held. Enable has priority over a coincident step.
- ON:
  - level=MAX; snd_out<=snd_in (exact pass-through); acc<=0.
  - enable=0 -> RAMP_DOWN, prescaler<=0.
- RAMP_DOWN:
  - Mirror of RAMP_UP, with level<=level-1 on each step.
  - Reaching 0 -> IDLE on the same edge.
  - enable=1 -> RAMP_UP, prescaler<=0, level held (reversal mid-ramp resumes from the current level; no jump).
- Sigma-delta, active in RAMP_UP and RAMP_DOWN:
  - x = snd_in ? level : 0.
  - sum = acc + x, computed LEVEL_BITS+1 wide.
  - snd_out<=sum[LEVEL_BITS]; acc<=sum[LEVEL_BITS-1:0].
  - With snd_in=1 and level constant L, any window of 2^LEVEL_BITS consecutive cycles contains exactly L ones.
  - acc is not cleared at level steps.
- Timing: enable sampled high at edge k in IDLE gives level=1 at edge k+RAMP_DIV and ON at edge k+MAX*RAMP_DIV. Ramp-down timing is symmetric.
- RAMP_DIV=1: one step per cycle; the prescaler compare is always true.
- level never wraps; it saturates at 0 and MAX by construction of the transitions.
- Reset asserted mid-ramp: immediate return to the reset values, independent of clk.

Test Plan:
- Reset: rst_n=0 with snd_in toggling and enable=1 -> snd_out=0, level=0, state=0 throughout; the first clk after release enters RAMP_UP.
- Full fade-in (LEVEL_BITS=4, RAMP_DIV=4): enable rises at edge k -> level=1 at k+4, level=8 at k+32, state=2 and level=15 at k+60; afterwards snd_out equals snd_in delayed 1 cycle.
- Sigma-delta density (LEVEL_BITS=4, RAMP_DIV=256, snd_in=1): while level=4, every 16-cycle window has exactly 4 ones; at level=12, exactly 12 ones. With snd_in=0 the output is all zeros.
- Full fade-out from ON (LEVEL_BITS=4, RAMP_DIV=4): enable falls at edge m -> state=3, level=14 at m+4, state=0 and level=0 at m+60; snd_out=0 afterwards.
- Reversal: fade in to level=6, deassert enable, wait 8 cycles (level=4), reassert -> level climbs 5, 6, ... every 4 cycles with no jump; ON reached 44 cycles after reassertion.
- Async reset mid-ramp at level=9 -> snd_out, level and state go to 0 before the next clk edge; ramp restarts from 0 after release.
